multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/core_pkg.sv | 48 ++++
 rtl/multicycle_core_if.sv | 31 +++
 rtl/core_alu.sv | 28 ++
 rtl/multicycle_core.sv | 106 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states and
// instruction field extraction helpers (word layout {op, rd, rs1, rs2}).
package core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLTU = 3'b101,
        OP_ADDI = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    // Helpers take the word zero-extended to MAX_IW so one set serves any RW.
    localparam int MAX_IW = 32;
    typedef logic [MAX_IW-1:0] iword_t;

    function automatic iword_t field_mask(int rw);
        return (iword_t'(1) << rw) - iword_t'(1);
    endfunction

    function automatic opcode_e instr_op(iword_t w, int rw);
        return opcode_e'(w[3*rw +: 3]);
    endfunction

    function automatic iword_t instr_rd(iword_t w, int rw);
        return (w >> (2*rw)) & field_mask(rw);
    endfunction

    function automatic iword_t instr_rs1(iword_t w, int rw);
        return (w >> rw) & field_mask(rw);
    endfunction

    function automatic iword_t instr_rs2(iword_t w, int rw);
        return w & field_mask(rw);
    endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Control, program-load and debug signals of the multicycle core.
interface multicycle_core_if #(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 8,
    parameter int IMEM_DEPTH = 16
);
    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int IW = 3 + 3*RW;

    logic              start;
    logic              imem_we;
    logic [PW-1:0]     imem_waddr;
    logic [IW-1:0]     imem_wdata;
    logic [RW-1:0]     dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              busy;
    logic              done;
    logic [PW-1:0]     pc;

    modport master (
        output start, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  dbg_rdata, busy, done, pc
    );

    modport slave (
        input  start, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output dbg_rdata, busy, done, pc
    );

endinterface

// File: rtl/core_alu.sv
// Combinational ALU; arithmetic wraps modulo 2^DATA_W, no flags.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        // NOTE: default assigned before the case so no path leaves y_o unassigned (no latch).
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLTU: y_o = DATA_W'(a_i < b_i);
            OP_ADDI: y_o = a_i + b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Four-cycle-per-instruction core: FETCH, DECODE, EXEC, WB, with inline
// register file and instruction memory loaded while idle.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 8,
    parameter int IMEM_DEPTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    multicycle_core_if.slave bus
);

    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int IW = 3 + 3*RW;

    state_e            state_q, state_d;
    logic [PW-1:0]     pc_q;
    logic [IW-1:0]     ir_q;
    opcode_e           alu_op_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, res_q, alu_y;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [IW-1:0]     imem   [IMEM_DEPTH];

    opcode_e       dec_op;
    logic [RW-1:0] dec_rd, dec_rs1, dec_rs2;

    assign dec_op  = instr_op(MAX_IW'(ir_q), RW);
    assign dec_rd  = RW'(instr_rd(MAX_IW'(ir_q), RW));
    assign dec_rs1 = RW'(instr_rs1(MAX_IW'(ir_q), RW));
    assign dec_rs2 = RW'(instr_rs2(MAX_IW'(ir_q), RW));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state elements use non-blocking assignments so all flops update together at the edge.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (dec_op == OP_HALT) begin
                    state_d  = S_IDLE;
                    bus.done = 1'b1;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: program memory is deliberately left without a reset so code survives rst_n.
    always_ff @(posedge clk) begin
        if (bus.imem_we && state_q == S_IDLE) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (alu_op_q),
        .a_i  (op_a_q),
        .b_i  (op_b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ir_q     <= '0;
            alu_op_q <= OP_ADD;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.start) pc_q <= '0;
                S_FETCH:  ir_q <= imem[pc_q];
                S_DECODE: begin
                    alu_op_q <= dec_op;
                    op_a_q   <= regs_q[dec_rs1];
                    // ADDI reuses the rs2 field as a zero-extended immediate.
                    op_b_q   <= (dec_op == OP_ADDI) ? DATA_W'(dec_rs2) : regs_q[dec_rs2];
                end
                S_EXEC:   res_q <= alu_y;
                S_WB: begin
                    regs_q[dec_rd] <= res_q;
                    pc_q           <= pc_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.dbg_rdata = regs_q[bus.dbg_raddr];

endmodule
